// File: rtl/decode_queue.sv
// decode_queue: instruction decode queue between fetch and issue.
//
// Buffers fetched (pc, instr) pairs in a DEPTH-entry circular FIFO and presents
// up to LANES of the oldest entries each cycle, already decoded into format,
// register indices, sign-extended immediate and an illegal-instruction flag.
//
// Ports:
//   clk, resetn   rising-edge clock, asynchronous active-low reset
//   flush         discard every entry (a push or pop in the same cycle is ignored)
//   in_valid/in_ready/in_pc/in_instr   fetch side
//   out_valid     lane i holds the i-th oldest entry
//   out_accept    number of lanes consumed this cycle (always a prefix)
//   out_pc/out_instr/out_fmt/out_rd/out_rs1/out_rs2/out_imm/out_illegal  per-lane decode
//   count         occupied entries
//
// Handshake: an entry transfers on a rising edge where in_valid && in_ready
// (and no flush). in_ready depends only on the registered count, so a pop
// in the same cycle does not free room for a push. out_valid[i] is set while
// count > i. Issue consumes lanes 0..out_accept-1 on the edge, and the pop is
// clamped to count. The issue side has no ready; out_accept is its consume signal.
module decode_queue #(
  parameter int DEPTH = 4,
  parameter int LANES = 2,
  parameter int XLEN  = 64
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [XLEN-1:0]              in_pc,
  input  logic [31:0]                  in_instr,
  output logic [LANES-1:0]             out_valid,
  input  logic [$clog2(LANES+1)-1:0]   out_accept,
  output logic [LANES*XLEN-1:0]        out_pc,
  output logic [LANES*32-1:0]          out_instr,
  output logic [LANES*3-1:0]           out_fmt,
  output logic [LANES*5-1:0]           out_rd,
  output logic [LANES*5-1:0]           out_rs1,
  output logic [LANES*5-1:0]           out_rs2,
  output logic [LANES*XLEN-1:0]        out_imm,
  output logic [LANES-1:0]             out_illegal,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_R    = 3'd1;
  localparam logic [2:0] FMT_I    = 3'd2;
  localparam logic [2:0] FMT_S    = 3'd3;
  localparam logic [2:0] FMT_B    = 3'd4;
  localparam logic [2:0] FMT_U    = 3'd5;
  localparam logic [2:0] FMT_J    = 3'd6;
  localparam logic [2:0] FMT_SYS  = 3'd7;

  typedef struct packed {
    logic [2:0]      fmt;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic            illegal;
  } dec_t;

  // Pure decode of one raw instruction. Illegal encodings come back with
  // every field zero except the illegal flag.
  function automatic dec_t decode(input logic [31:0] ins);
    dec_t       d;
    logic [6:0] f7;
    logic [2:0] f3;
    logic       legal;
    logic [2:0] fmt;
    f7    = ins[31:25];
    f3    = ins[14:12];
    legal = 1'b0;
    fmt   = FMT_NONE;
    d     = '0;
    // Every supported opcode ends in 2'b11, so compressed encodings fall to default.
    case (ins[6:0])
      7'b0110011: begin
        fmt   = FMT_R;
        legal = (f7 == 7'h00) || (f7 == 7'h01) ||
                (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101));
      end
      7'b0111011: begin
        fmt   = FMT_R;
        legal = (f7 == 7'h00 && (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b101)) ||
                (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)) ||
                (f7 == 7'h01 && (f3 == 3'b000 || f3 >= 3'b100));
      end
      7'b0010011: begin
        fmt = FMT_I;
        if (f3 == 3'b001)      legal = (ins[31:26] == 6'b000000);
        else if (f3 == 3'b101) legal = (ins[31:26] == 6'b000000) || (ins[31:26] == 6'b010000);
        else                   legal = 1'b1;
      end
      7'b0011011: begin
        fmt = FMT_I;
        if (f3 == 3'b000)      legal = 1'b1;
        else if (f3 == 3'b001) legal = (f7 == 7'h00);
        else if (f3 == 3'b101) legal = (f7 == 7'h00) || (f7 == 7'h20);
        else                   legal = 1'b0;
      end
      7'b0000011: begin fmt = FMT_I; legal = (f3 != 3'b111); end
      7'b1100111: begin fmt = FMT_I; legal = (f3 == 3'b000); end
      7'b0100011: begin fmt = FMT_S; legal = !f3[2]; end
      7'b1100011: begin fmt = FMT_B; legal = (f3 != 3'b010) && (f3 != 3'b011); end
      7'b0110111, 7'b0010111: begin fmt = FMT_U; legal = 1'b1; end
      7'b1101111: begin fmt = FMT_J; legal = 1'b1; end
      7'b1110011: begin
        fmt = FMT_SYS;
        if (f3 == 3'b000)      legal = (ins == 32'h0000_0073) || (ins == 32'h3020_0073);
        else if (f3 == 3'b100) legal = 1'b0;
        else                   legal = 1'b1;
      end
      default: legal = 1'b0;
    endcase

    if (legal) begin
      d.fmt = fmt;
      d.rd  = ins[11:7];
      d.rs1 = ins[19:15];
      d.rs2 = ins[24:20];
      case (fmt)
        FMT_I:   begin d.rs2 = '0; d.imm = XLEN'($signed(ins[31:20])); end
        FMT_S:   begin d.rd = '0; d.imm = XLEN'($signed({ins[31:25], ins[11:7]})); end
        FMT_B:   begin
          d.rd  = '0;
          d.imm = XLEN'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
        end
        FMT_U:   begin d.rs1 = '0; d.rs2 = '0; d.imm = XLEN'($signed({ins[31:12], 12'b0})); end
        FMT_J:   begin
          d.rs1 = '0;
          d.rs2 = '0;
          d.imm = XLEN'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
        end
        FMT_SYS: begin
          d.rs2 = '0;
          // Immediate CSR forms reuse the rs1 field as a 5-bit zero-extended value.
          if (f3[2]) begin
            d.imm = XLEN'(ins[19:15]);
            d.rs1 = '0;
          end
        end
        default: d.imm = '0;
      endcase
    end else begin
      d.illegal = 1'b1;
    end
    return d;
  endfunction

  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [31:0]     instr_mem [DEPTH];
  logic [PW-1:0]   head, tail;
  logic            push;
  logic [CW-1:0]   acc_ext, pop_n;

  assign in_ready = (count < CW'(DEPTH));
  assign push     = in_valid && in_ready && !flush;
  assign acc_ext  = CW'(out_accept);
  assign pop_n    = (acc_ext > count) ? count : acc_ext;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      // DEPTH is a power of two, so truncating the pop amount wraps correctly.
      head  <= head + pop_n[PW-1:0];
      count <= count + CW'(push) - pop_n;
    end
  end

  // Storage needs no reset: lanes are masked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail]    <= in_pc;
      instr_mem[tail] <= in_instr;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [PW-1:0] idx;
    logic          valid;
    dec_t          d;
    assign idx   = head + PW'(i);
    assign valid = (count > CW'(i));
    assign d     = decode(instr_mem[idx]);

    assign out_valid[i]            = valid;
    assign out_pc[i*XLEN +: XLEN]  = valid ? pc_mem[idx]    : '0;
    assign out_instr[i*32 +: 32]   = valid ? instr_mem[idx] : '0;
    assign out_fmt[i*3 +: 3]       = valid ? d.fmt : '0;
    assign out_rd[i*5 +: 5]        = valid ? d.rd  : '0;
    assign out_rs1[i*5 +: 5]       = valid ? d.rs1 : '0;
    assign out_rs2[i*5 +: 5]       = valid ? d.rs2 : '0;
    assign out_imm[i*XLEN +: XLEN] = valid ? d.imm : '0;
    assign out_illegal[i]          = valid && d.illegal;
  end

endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
Parametrised instruction decode queue between fetch and issue. It buffers fetched (pc, instr) pairs in a DEPTH-entry circular FIFO. Each cycle it presents up to LANES head entries, already decoded into format, register indices, sign-extended immediate and an illegal-instruction flag. Issue consumes a prefix of the valid lanes; a redirect flushes the queue.

Parameters:
DEPTH, 4, queue entries; power of 2, >= 2
LANES, 2, decoded output lanes; 1 or 2, <= DEPTH
XLEN, 64, pc/immediate width

Ports:
clk  in  1  clock, rising edge
resetn  in  1  asynchronous active-low reset
flush  in  1  discard all entries
in_valid  in  1  fetch offers an instruction
in_ready  out  1  queue can accept
in_pc  in  XLEN  pc of offered instruction
in_instr  in  32  raw instruction
out_valid  out  LANES  lane i holds the i-th oldest entry
out_accept  in  $clog2(LANES+1)  number of lanes consumed this cycle, always a prefix
out_pc  out  LANES*XLEN  per-lane pc
out_instr  out  LANES*32  per-lane raw instruction
out_fmt  out  LANES*3  0 NONE, 1 R, 2 I, 3 S, 4 B, 5 U, 6 J, 7 SYS
out_rd / out_rs1 / out_rs2  out  LANES*5 each  register indices; 0 when the field is unused
out_imm  out  LANES*XLEN  sign-extended immediate
out_illegal  out  LANES  lane holds an unsupported encoding
count  out  $clog2(DEPTH+1)  occupied entries

Behaviour:
- Reset (resetn=0, asynchronous): head, tail and count = 0. in_ready = 1. out_valid = 0. All lane data outputs are 0.
- Storage: registered array of {pc, instr}. Pointers wrap modulo DEPTH.
- Push: occurs when in_valid && in_ready. The entry is written at tail and tail advances.
- in_ready = (count < DEPTH). It depends on registered count only, so there is no same-cycle pop credit: when full, a simultaneous pop does not allow a push.
- Latency: a pushed entry is visible on lane 0 the next cycle at the earliest, and never in the same cycle it is pushed.
- Lanes:
  - out_valid[i] = (count > i).
  - Lane i decodes entry (head+i) mod DEPTH combinationally from registered state.
  - Invalid lanes drive all data outputs to 0.
- Pop: head advances by min(out_accept, count). Any excess out_accept is clamped; the bench flags it as a protocol error.
- Count update: count_next = count + push - pop. Push and pop may occur in the same cycle.
- Flush (synchronous, highest priority): head, tail and count go to 0 and out_valid goes to 0 next cycle. A push in the flush cycle is dropped. Pop in the flush cycle is ignored.
- Decode fields per lane:
  - instr[1:0] != 2'b11 -> illegal, fmt NONE.
  - opcode 0110011 -> R:
    - f7 0000000: any f3 legal.
    - f7 0100000: only f3 000 or 101.
    - f7 0000001: any f3.
    - Other f7 -> illegal.
  - opcode 0111011 -> R:
    - f7 0000000: f3 in {000, 001, 101}.
    - f7 0100000: f3 in {000, 101}.
    - f7 0000001: f3 in {000, 100, 101, 110, 111}.
    - Otherwise illegal.
  - opcode 0010011 -> I:
    - f3 001 requires instr[31:26] = 0.
    - f3 101 requires instr[31:26] in {000000, 010000}.
  - opcode 0011011 -> I:
    - f3 000 legal.
    - f3 001 requires f7 = 0.
    - f3 101 requires f7 in {0000000, 0100000}.
    - Other f3 illegal.
  - opcode 0000011 -> I: f3 111 is illegal.
  - opcode 1100111 (jalr) -> I: requires f3 000.
  - opcode 0100011 -> S: f3 in 000..011.
  - opcode 1100011 -> B: f3 010 and 011 are illegal.
  - opcode 0110111 / 0010111 -> U.
  - opcode 1101111 -> J.
  - opcode 1110011 -> SYS:
    - f3 in {001, 010, 011, 101, 110, 111} legal.
    - f3 000 legal only for 0x00000073 or 0x30200073.
    - Otherwise illegal.
  - Any other opcode -> illegal, fmt NONE.
- Immediates:
  - I = sext(instr[31:20]).
  - S = sext({instr[31:25], instr[11:7]}).
  - B = sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - U = sext({instr[31:12], 12'b0}) to XLEN.
  - J = sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
  - SYS with f3[2] = 1: imm = zext(instr[19:15]) and rs1 = 0.
  - R and other SYS forms: imm = 0.
- Register index masking:
  - rd = 0 for S and B.
  - rs2 = 0 for I, U, J and SYS.
  - rs1 = 0 for U and J.
- Illegal lanes: out_fmt = 0 and out_imm = 0. out_pc and out_instr stay valid, and rd/rs1/rs2 = 0. Illegal lanes are popped normally.

Test Plan:
- Basic decode: reset, then push pc=0x80000000 instr=0x00500093 -> next cycle out_valid=01, fmt=2, rd=1, rs1=0, imm=5, illegal=0. Accept 1 -> count=0.
- Two-lane decode: push 0x0020A423 then 0xFE000EE3 with no accept -> lane0 fmt=3, rs1=1, rs2=2, rd=0, imm=8. Lane1 fmt=4, imm=0xFFFFFFFFFFFFFFFC. out_accept=2 -> count 0.
- Fill and wrap: push 4 entries with accept=0 -> count=4, in_ready=0. Hold in_valid with accept=1 -> no push that cycle, push next. Repeat 10 iterations -> pointers wrap and pc order is preserved.
- Flush: with 3 entries, flush=1 together with in_valid=1 and accept=2 -> next cycle count=0 and out_valid=00. The flushed-cycle push is absent.
- Illegal encodings: push 0x00000000, 0x4000F033 and 0x00007003 -> all flagged illegal with fmt=0 and pop normally. 0x30200073 -> fmt=7, illegal=0.
- Async reset: assert resetn=0 mid-stream between clock edges -> out_valid=00 and count=0 immediately, in_ready=1.
